// File: rtl/axi4_protocol_checker_pkg.sv
// axi_parameters: shared AXI widths and the protocol checker error codes.
// Provides axi_chk_err_e, AXI_CHK_NUM_ERR and chk_first_err().
package axi_parameters;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int AXI_CHK_NUM_ERR = 12;

    typedef enum logic [3:0] {
        ERR_NONE          = 4'd0,
        ERR_AW_UNSTABLE   = 4'd1,
        ERR_W_UNSTABLE    = 4'd2,
        ERR_B_UNSTABLE    = 4'd3,
        ERR_AR_UNSTABLE   = 4'd4,
        ERR_R_UNSTABLE    = 4'd5,
        ERR_WLAST_EARLY   = 4'd6,
        ERR_WLAST_MISSING = 4'd7,
        ERR_W_NO_AW       = 4'd8,
        ERR_B_NO_WRITE    = 4'd9,
        ERR_RLAST_NO_READ = 4'd10,
        ERR_WR_OVERFLOW   = 4'd11,
        ERR_RD_OVERFLOW   = 4'd12
    } axi_chk_err_e;

    // Lowest set bit wins; bit n-1 carries code n.
    function automatic axi_chk_err_e chk_first_err(
        input logic [AXI_CHK_NUM_ERR-1:0] v
    );
        axi_chk_err_e e;
        e = ERR_NONE;
        for (int i = AXI_CHK_NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) e = axi_chk_err_e'(4'(i + 1));
        end
        return e;
    endfunction

endpackage

// File: rtl/axi4_chk_len_fifo.sv
// axi4_chk_len_fifo: synchronous FIFO of AWLEN values awaiting W data.
// Ports: clk, rst_n, push/pop/din in; head, full, empty out.
module axi4_chk_len_fifo
    import axi_parameters::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so push is legal even when full.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/axi4_protocol_checker.sv
// axi4_protocol_checker: passive AXI4 monitor; taps AW/W/B/AR/R inputs and
// reports err_valid/err_code/err_vector/err_count plus outstanding counts.
// Optional macro AXI4_CHK_ASSERT_EN adds one concurrent assertion per code.
module axi4_protocol_checker
    import axi_parameters::*;
#(
    parameter int ID_WIDTH        = 9,
    parameter int ADDR_WIDTH      = axi_parameters::ADDR_WIDTH,
    parameter int DATA_WIDTH      = axi_parameters::DATA_WIDTH,
    parameter int LEN_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ID_WIDTH-1:0]           awid,
    input  logic [ADDR_WIDTH-1:0]         awaddr,
    input  logic [LEN_WIDTH-1:0]          awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          awlock,
    input  logic [3:0]                    awcache,
    input  logic [2:0]                    awprot,
    input  logic [3:0]                    awqos,
    input  logic                          awvalid,
    input  logic                          awready,
    input  logic [ID_WIDTH-1:0]           wid,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    input  logic                          wready,
    input  logic [ID_WIDTH-1:0]           bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    input  logic                          bready,
    input  logic [ID_WIDTH-1:0]           arid,
    input  logic [ADDR_WIDTH-1:0]         araddr,
    input  logic [LEN_WIDTH-1:0]          arlen,
    input  logic [2:0]                    arsize,
    input  logic [1:0]                    arburst,
    input  logic                          arlock,
    input  logic [3:0]                    arcache,
    input  logic [2:0]                    arprot,
    input  logic [3:0]                    arqos,
    input  logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_WIDTH-1:0]           rid,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    input  logic                          rready,
    output logic                          err_valid,
    output logic [3:0]                    err_code,
    output logic [AXI_CHK_NUM_ERR-1:0]    err_vector,
    output logic [15:0]                   err_count,
    output logic [$clog2(MAX_OUTSTANDING):0] wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0] rd_outstanding
);

    localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int AXP = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 17;
    localparam int WP  = ID_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int BP  = ID_WIDTH + 2;
    localparam int RP  = ID_WIDTH + DATA_WIDTH + 3;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic [AXP-1:0] aw_pl, aw_cp, ar_pl, ar_cp;
    logic [WP-1:0]  w_pl, w_cp;
    logic [BP-1:0]  b_pl, b_cp;
    logic [RP-1:0]  r_pl, r_cp;
    logic [4:0]     pend;
    logic [4:0]     vld;
    logic [4:0]     rdy;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AXI_CHK_NUM_ERR-1:0] viol, viol_q;
    logic [LEN_WIDTH-1:0] beat, beat_nx, len_head;
    logic [CW-1:0] wr_done;
    logic push, pop, len_full, len_empty, unused_full;
    logic wr_inc, wr_dec, rd_inc, rd_dec, done_inc, done_dec;

    assign aw_pl = {awid, awaddr, awlen, awsize, awburst,
                    awlock, awcache, awprot, awqos};
    assign ar_pl = {arid, araddr, arlen, arsize, arburst,
                    arlock, arcache, arprot, arqos};
    assign w_pl  = {wid, wdata, wstrb, wlast};
    assign b_pl  = {bid, bresp};
    assign r_pl  = {rid, rdata, rresp, rlast};
    assign vld   = {rvalid, arvalid, bvalid, wvalid, awvalid};
    assign rdy   = {rready, arready, bready, wready, awready};

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // The entry count never exceeds wr_outstanding, so the
    // outstanding limit already bounds the FIFO.
    assign unused_full = len_full;

    axi4_chk_len_fifo #(
        .WIDTH (LEN_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (awlen),
        .head  (len_head),
        .full  (len_full),
        .empty (len_empty)
    );

    always_comb begin
        viol     = '0;
        push     = 1'b0;
        pop      = 1'b0;
        beat_nx  = beat;
        wr_inc   = 1'b0;
        wr_dec   = 1'b0;
        rd_inc   = 1'b0;
        rd_dec   = 1'b0;
        done_inc = 1'b0;
        done_dec = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pend[i] && !vld[i]) viol[i] = 1'b1;
        end
        if (pend[0] && vld[0] && aw_pl != aw_cp) viol[0] = 1'b1;
        if (pend[1] && vld[1] && w_pl != w_cp)   viol[1] = 1'b1;
        if (pend[2] && vld[2] && b_pl != b_cp)   viol[2] = 1'b1;
        if (pend[3] && vld[3] && ar_pl != ar_cp) viol[3] = 1'b1;
        if (pend[4] && vld[4] && r_pl != r_cp)   viol[4] = 1'b1;
        if (aw_hs) begin
            if (wr_outstanding == MAX_C) viol[10] = 1'b1;
            else begin
                push   = 1'b1;
                wr_inc = 1'b1;
            end
        end
        if (w_hs) begin
            if (len_empty) viol[7] = 1'b1;
            else if (wlast || beat == len_head) begin
                // Any burst termination, right or wrong, retires the entry.
                viol[5]  = wlast && (beat != len_head);
                viol[6]  = !wlast;
                pop      = 1'b1;
                beat_nx  = '0;
                done_inc = 1'b1;
            end else begin
                beat_nx = beat + 1'b1;
            end
        end
        if (b_hs) begin
            if (wr_done == '0) viol[8] = 1'b1;
            else begin
                done_dec = 1'b1;
                wr_dec   = 1'b1;
            end
        end
        if (ar_hs) begin
            if (rd_outstanding == MAX_C) viol[11] = 1'b1;
            else rd_inc = 1'b1;
        end
        if (r_hs && rlast) begin
            if (rd_outstanding == '0) viol[9] = 1'b1;
            else rd_dec = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            aw_cp <= '0;
            w_cp  <= '0;
            b_cp  <= '0;
            ar_cp <= '0;
            r_cp  <= '0;
        end else begin
            pend <= vld & ~rdy;
            if (awvalid && !awready) aw_cp <= aw_pl;
            if (wvalid && !wready)   w_cp  <= w_pl;
            if (bvalid && !bready)   b_cp  <= b_pl;
            if (arvalid && !arready) ar_cp <= ar_pl;
            if (rvalid && !rready)   r_cp  <= r_pl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat           <= '0;
            wr_done        <= '0;
            wr_outstanding <= '0;
            rd_outstanding <= '0;
        end else begin
            beat           <= beat_nx;
            wr_done        <= wr_done + CW'(done_inc) - CW'(done_dec);
            wr_outstanding <= wr_outstanding + CW'(wr_inc) - CW'(wr_dec);
            rd_outstanding <= rd_outstanding + CW'(rd_inc) - CW'(rd_dec);
        end
    end

    // Violations are captured first, then published one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q     <= '0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_vector <= '0;
            err_count  <= '0;
        end else begin
            viol_q    <= viol;
            err_valid <= |viol_q;
            if (|viol_q) begin
                err_code   <= chk_first_err(viol_q);
                err_vector <= err_vector | viol_q;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end

`ifdef AXI4_CHK_ASSERT_EN
    a_aw_unst: assert property (@(posedge clk) disable iff (!rst_n) !viol[0])
        else $error("AW_UNSTABLE id=%0h", awid);
    a_w_unst: assert property (@(posedge clk) disable iff (!rst_n) !viol[1])
        else $error("W_UNSTABLE id=%0h", wid);
    a_b_unst: assert property (@(posedge clk) disable iff (!rst_n) !viol[2])
        else $error("B_UNSTABLE id=%0h", bid);
    a_ar_unst: assert property (@(posedge clk) disable iff (!rst_n) !viol[3])
        else $error("AR_UNSTABLE id=%0h", arid);
    a_r_unst: assert property (@(posedge clk) disable iff (!rst_n) !viol[4])
        else $error("R_UNSTABLE id=%0h", rid);
    a_wl_early: assert property (@(posedge clk) disable iff (!rst_n) !viol[5])
        else $error("WLAST_EARLY id=%0h", wid);
    a_wl_miss: assert property (@(posedge clk) disable iff (!rst_n) !viol[6])
        else $error("WLAST_MISSING id=%0h", wid);
    a_w_no_aw: assert property (@(posedge clk) disable iff (!rst_n) !viol[7])
        else $error("W_NO_AW id=%0h", wid);
    a_b_no_wr: assert property (@(posedge clk) disable iff (!rst_n) !viol[8])
        else $error("B_NO_WRITE id=%0h", bid);
    a_r_no_rd: assert property (@(posedge clk) disable iff (!rst_n) !viol[9])
        else $error("RLAST_NO_READ id=%0h", rid);
    a_wr_ovf: assert property (@(posedge clk) disable iff (!rst_n) !viol[10])
        else $error("WR_OVERFLOW id=%0h", awid);
    a_rd_ovf: assert property (@(posedge clk) disable iff (!rst_n) !viol[11])
        else $error("RD_OVERFLOW id=%0h", arid);
`endif

endmodule

// File: tb/tb_axi4_protocol_checker.sv
// tb_axi4_protocol_checker: directed scenarios for axi4_protocol_checker.
// Drives on the falling edge, samples on the falling edge.
module tb_axi4_protocol_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, awcache, arcache, awqos, arqos, wstrb;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock, wlast, rlast;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [11:0] err_vector;
    logic [15:0] err_count;
    logic [3:0]  wr_outstanding, rd_outstanding;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi4_protocol_checker dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awqos(awqos), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arqos(arqos), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .err_valid(err_valid), .err_code(err_code), .err_vector(err_vector),
        .err_count(err_count), .wr_outstanding(wr_outstanding),
        .rd_outstanding(rd_outstanding)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        {awid, wid, bid, arid, rid} = '0;
        {awaddr, araddr, wdata, rdata} = '0;
        {awlen, arlen, awcache, arcache, awqos, arqos} = '0;
        wstrb = 4'hF;
        {awsize, arsize, awprot, arprot} = '0;
        {awburst, arburst, bresp, rresp} = '0;
        {awlock, arlock, wlast, rlast} = '0;
        {awvalid, wvalid, bvalid, arvalid, rvalid} = '0;
        {awready, wready, bready, arready, rready} = 5'h1F;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic aw_hs(input logic [3:0] len);
        awvalid = 1'b1;
        awlen = len;
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_hs(input logic last);
        wvalid = 1'b1;
        wlast = last;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic b_hs();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++; if (err_valid !== 1'b0) begin errors++;
            $display("FAIL reset_err_valid got=%0b exp=0", err_valid); end
        checks++; if (err_code !== 4'd0) begin errors++;
            $display("FAIL reset_err_code got=%0d exp=0", err_code); end
        checks++; if (err_vector !== 12'h000) begin errors++;
            $display("FAIL reset_err_vector got=%h exp=000", err_vector); end
        checks++; if (err_count !== 16'd0) begin errors++;
            $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        checks++; if (wr_outstanding !== 4'd0) begin errors++;
            $display("FAIL reset_wr_out got=%0d exp=0", wr_outstanding); end
        checks++; if (rd_outstanding !== 4'd0) begin errors++;
            $display("FAIL reset_rd_out got=%0d exp=0", rd_outstanding); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_clean_burst();
        do_reset();
        aw_hs(4'd3);
        checks++; if (wr_outstanding !== 4'd1) begin errors++;
            $display("FAIL clean_wr_out_after_aw got=%0d exp=1", wr_outstanding); end
        w_hs(1'b0); w_hs(1'b0); w_hs(1'b0); w_hs(1'b1);
        b_hs();
        checks++; if (wr_outstanding !== 4'd0) begin errors++;
            $display("FAIL clean_wr_out_after_b got=%0d exp=0", wr_outstanding); end
        tick(); tick();
        checks++; if (err_count !== 16'd0) begin errors++;
            $display("FAIL clean_err_count got=%0d exp=0", err_count); end
        checks++; if (err_vector !== 12'h000) begin errors++;
            $display("FAIL clean_err_vector got=%h exp=000", err_vector); end
    endtask

    task automatic test_wlast_early();
        do_reset();
        aw_hs(4'd3);
        w_hs(1'b0);
        w_hs(1'b1);
        checks++; if (err_valid !== 1'b0) begin errors++;
            $display("FAIL early_latency got=%0b exp=0", err_valid); end
        tick();
        checks++; if (err_valid !== 1'b1) begin errors++;
            $display("FAIL early_err_valid got=%0b exp=1", err_valid); end
        checks++; if (err_code !== 4'd6) begin errors++;
            $display("FAIL early_err_code got=%0d exp=6", err_code); end
        tick();
        checks++; if (err_valid !== 1'b0) begin errors++;
            $display("FAIL early_pulse_width got=%0b exp=0", err_valid); end
        checks++; if (err_code !== 4'd6) begin errors++;
            $display("FAIL early_code_hold got=%0d exp=6", err_code); end
        aw_hs(4'd0);
        w_hs(1'b1);
        b_hs();
        b_hs();
        tick(); tick();
        checks++; if (err_count !== 16'd1) begin errors++;
            $display("FAIL early_followup_count got=%0d exp=1", err_count); end
        checks++; if (err_vector !== 12'h020) begin errors++;
            $display("FAIL early_followup_vector got=%h exp=020", err_vector); end
        checks++; if (wr_outstanding !== 4'd0) begin errors++;
            $display("FAIL early_followup_wr_out got=%0d exp=0", wr_outstanding); end
    endtask

    task automatic test_stability();
        do_reset();
        awready = 1'b0;
        awvalid = 1'b1;
        awaddr = 32'h100;
        tick();
        awaddr = 32'h104;
        tick();
        tick();
        checks++; if (err_valid !== 1'b1) begin errors++;
            $display("FAIL aw_unstable_valid got=%0b exp=1", err_valid); end
        checks++; if (err_code !== 4'd1) begin errors++;
            $display("FAIL aw_unstable_code got=%0d exp=1", err_code); end
        checks++; if (err_vector[0] !== 1'b1) begin errors++;
            $display("FAIL aw_unstable_vec0 got=%0b exp=1", err_vector[0]); end
        awready = 1'b1;
        tick();
        awvalid = 1'b0;
        awaddr = '0;
        checks++; if (err_valid !== 1'b0) begin errors++;
            $display("FAIL aw_stable_after got=%0b exp=0", err_valid); end
        checks++; if (wr_outstanding !== 4'd1) begin errors++;
            $display("FAIL aw_stall_wr_out got=%0d exp=1", wr_outstanding); end
        wready = 1'b0;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        wready = 1'b1;
        tick();
        checks++; if (err_code !== 4'd2) begin errors++;
            $display("FAIL w_drop_code got=%0d exp=2", err_code); end
        checks++; if (err_vector !== 12'h003) begin errors++;
            $display("FAIL w_drop_vector got=%h exp=003", err_vector); end
    endtask

    task automatic test_reset_exit();
        idle();
        rst_n = 1'b0;
        bvalid = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        bvalid = 1'b0;
        tick();
        checks++; if (err_valid !== 1'b1 || err_code !== 4'd9) begin errors++;
            $display("FAIL b_no_write got=%0b/%0d exp=1/9", err_valid, err_code); end
        checks++; if (err_vector !== 12'h100) begin errors++;
            $display("FAIL b_no_write_vec got=%h exp=100", err_vector); end
        rst_n = 1'b0;
        bvalid = 1'b1;
        wvalid = 1'b1;
        wlast = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        {bvalid, wvalid, wlast} = '0;
        tick();
        checks++; if (err_code !== 4'd8) begin errors++;
            $display("FAIL w_no_aw_code got=%0d exp=8", err_code); end
        checks++; if (err_vector !== 12'h180) begin errors++;
            $display("FAIL w_no_aw_vec got=%h exp=180", err_vector); end
        checks++; if (err_count !== 16'd1) begin errors++;
            $display("FAIL w_no_aw_count got=%0d exp=1", err_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        arvalid = 1'b1;
        repeat (8) tick();
        checks++; if (rd_outstanding !== 4'd8 || err_valid !== 1'b0) begin errors++;
            $display("FAIL rd_fill got=%0d/%0b exp=8/0", rd_outstanding, err_valid); end
        tick();
        arvalid = 1'b0;
        checks++; if (rd_outstanding !== 4'd8) begin errors++;
            $display("FAIL rd_ovf_hold got=%0d exp=8", rd_outstanding); end
        tick();
        checks++; if (err_valid !== 1'b1 || err_code !== 4'd12) begin errors++;
            $display("FAIL rd_ovf_code got=%0b/%0d exp=1/12", err_valid, err_code); end
        rvalid = 1'b1;
        rlast = 1'b1;
        repeat (8) tick();
        rvalid = 1'b0;
        checks++; if (rd_outstanding !== 4'd0) begin errors++;
            $display("FAIL rd_drain got=%0d exp=0", rd_outstanding); end
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        rlast = 1'b0;
        tick();
        checks++; if (err_code !== 4'd10) begin errors++;
            $display("FAIL rlast_no_read got=%0d exp=10", err_code); end
        checks++; if (err_vector !== 12'hA00) begin errors++;
            $display("FAIL rd_vector got=%h exp=A00", err_vector); end
        awvalid = 1'b1;
        repeat (9) tick();
        awvalid = 1'b0;
        tick();
        checks++; if (err_code !== 4'd11 || wr_outstanding !== 4'd8) begin errors++;
            $display("FAIL wr_ovf got=%0d/%0d exp=11/8", err_code, wr_outstanding); end
        checks++; if (err_count !== 16'd3) begin errors++;
            $display("FAIL ovf_count got=%0d exp=3", err_count); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        b_hs();
        aw_hs(4'd7);
        repeat (4) w_hs(1'b0);
        checks++; if (err_count !== 16'd1 || wr_outstanding !== 4'd1) begin errors++;
            $display("FAIL mid_pre got=%0d/%0d exp=1/1", err_count, wr_outstanding); end
        wvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({err_valid, err_code, err_vector} !== 17'd0) begin errors++;
            $display("FAIL mid_rst_err got=%0b/%0d/%h exp=0", err_valid, err_code, err_vector); end
        checks++; if (err_count !== 16'd0) begin errors++;
            $display("FAIL mid_rst_count got=%0d exp=0", err_count); end
        checks++; if (wr_outstanding !== 4'd0 || rd_outstanding !== 4'd0) begin errors++;
            $display("FAIL mid_rst_out got=%0d/%0d exp=0/0", wr_outstanding, rd_outstanding); end
        wvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        aw_hs(4'd1);
        w_hs(1'b0);
        w_hs(1'b1);
        b_hs();
        tick(); tick();
        checks++; if (err_count !== 16'd0 || err_vector !== 12'h000) begin errors++;
            $display("FAIL mid_after got=%0d/%h exp=0/000", err_count, err_vector); end
        checks++; if (wr_outstanding !== 4'd0) begin errors++;
            $display("FAIL mid_after_wr_out got=%0d exp=0", wr_outstanding); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        awvalid = 1'b1;
        awlen = 4'd1;
        tick();
        awlen = 4'd0;
        wvalid = 1'b1;
        tick();
        checks++; if (wr_outstanding !== 4'd2) begin errors++;
            $display("FAIL b2b_two got=%0d exp=2", wr_outstanding); end
        awvalid = 1'b0;
        wlast = 1'b1;
        tick();
        bvalid = 1'b1;
        tick();
        checks++; if (wr_outstanding !== 4'd1) begin errors++;
            $display("FAIL b2b_w_and_b got=%0d exp=1", wr_outstanding); end
        {wvalid, wlast} = '0;
        tick();
        bvalid = 1'b0;
        checks++; if (wr_outstanding !== 4'd0) begin errors++;
            $display("FAIL b2b_drain got=%0d exp=0", wr_outstanding); end
        aw_hs(4'd0);
        w_hs(1'b1);
        awvalid = 1'b1;
        bvalid = 1'b1;
        tick();
        {awvalid, bvalid} = '0;
        checks++; if (wr_outstanding !== 4'd1) begin errors++;
            $display("FAIL b2b_cancel got=%0d exp=1", wr_outstanding); end
        w_hs(1'b1);
        b_hs();
        tick(); tick();
        checks++; if (wr_outstanding !== 4'd0 || err_count !== 16'd0) begin errors++;
            $display("FAIL b2b_end got=%0d/%0d exp=0/0", wr_outstanding, err_count); end
    endtask

    initial begin
        test_reset();
        test_clean_burst();
        test_wlast_early();
        test_stability();
        test_reset_exit();
        test_overflow();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
